dhash_motion_ctrl: RTL and testbench
====================================

Name: dhash_motion_ctrl

Overview:
Controller that sequences the ping-pong signature RAM behind the dHash camera block once per frame. On each frame-done pulse it reads the four 32-bit signature words and computes the Hamming distance against the previous frame's signature. It compares that distance with a programmable threshold and raises a motion flag and interrupt. The CPU configures and reads it through the custom-instruction interface; it lives entirely in the system clock domain.

Parameters:
customId, 8'd0, custom-instruction id this block answers to
nrOfWords, 4, signature words per frame (128-bit signature)
thresholdReset, 8'd10, threshold value loaded at reset

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
frameDone  in  1  single-cycle pulse, already synchronised to clock, new signature available
sigAddress  out  2  read address to signature RAM
sigData  in  32  RAM read data, valid 1 cycle after sigAddress
ciN  in  8  custom-instruction number
ciStart  in  1  custom-instruction start
ciValueA  in  32  [2:0] command select
ciValueB  in  32  command operand
ciResult  out  32  command result, 0 when not selected
ciDone  out  1  = ciStart & (ciN == customId), combinational
motionIrq  out  1  one-cycle pulse when motion is detected

Behaviour:
- One clock (clock); reset is synchronous and active-high.
- Reset values: state IDLE, sigAddress 0, motionIrq 0, motion flag 0, prevValid 0, distance 0, threshold thresholdReset, frameCount 0, overrunCount 0, previous-signature registers 0.
- FSM states: IDLE, READ, DONE.
  - IDLE: frameDone -> READ; wordIdx 0.
  - READ: drives sigAddress = wordIdx for nrOfWords consecutive cycles.
  - Data for word k is captured the cycle after address k is driven.
  - Per word: adds popcount(sigData XOR prevWord[k]) into an 8-bit accumulator (max 128, no overflow), then writes sigData into prevWord[k].
  - DONE is entered after the last capture.
- Latency: frameDone at cycle T gives addresses 0..3 at T+1..T+4 and captures at T+2..T+5.
  - DONE at T+6 updates distance and flags; motionIrq pulses at T+6; IDLE at T+7.
- In DONE:
  - If prevValid = 1 and distance >= threshold: motion flag set and motionIrq = 1.
  - If prevValid = 0: distance is forced to 0 and no irq fires.
  - frameCount += 1 (16 bit, wraps at 0xFFFF -> 0); prevValid is set to 1.
- frameDone while not IDLE: ignored; overrunCount += 1 (8 bit, saturates at 255).
- busy = (state != IDLE).
- CI commands (ciValueA[2:0]), effective only while ciDone = 1; register writes take effect at the next edge:
  - 0: read status {busy[31], motion[30], prevValid[29], 21'b0, distance[7:0]}
  - 1: write threshold <= ciValueB[7:0]; result 0
  - 2: read threshold (zero-extended)
  - 3: clear motion flag; result = status before clear
  - 4: read {overrunCount[23:16], frameCount[15:0]}
  - 5: read prevWord[ciValueB[1:0]]
  - 6: reset history: prevValid <= 0, counters <= 0; ignored if busy (result bit0 = 1 if rejected)
  - 7: reserved, result 0
- Simultaneous clear (cmd 3) and motion set in DONE: set wins.
- Threshold write during READ: applies to the current frame's compare in DONE.
- Reset mid-frame: returns to IDLE at once; partial accumulation is discarded; prevWord is cleared.

Optional Feature:
DHASH_CTRL_WORDMASK_EN
- Defined: adds a 4-bit word mask (reset 4'hF), written by cmd 7 from ciValueB[3:0] and read back by cmd 7 with operand bit31 = 1.
  - Masked-out words still update prevWord but contribute 0 to the distance.
- Undefined: all words are counted and cmd 7 stays reserved.

Decomposition:
- Shared package dhash_pkg:
  - FSM state encoding (IDLE/READ/DONE)
  - CI command codes CMD_STATUS..CMD_RSVD
  - status bit positions
  - SIG_WORD_WIDTH = 32, DIST_WIDTH = 8
- Sub-module popcount32: combinational 32-bit population count returning 6 bits, instantiated once in the capture path.

Test Plan:
- Reset, then cmd 2 -> ciResult = 10; cmd 0 -> 0x00000000; ciDone high only in the ciStart cycle with ciN = customId.
- First frameDone with words {FFFFFFFF, 0, 0, 0} -> no motionIrq, distance 0, prevValid 1; cmd 5 operand 0 -> 0xFFFFFFFF.
- Second frame with all words 0 -> distance 32 >= 10: motionIrq pulses at T+6; status = 0x40000020 plus prevValid bit (0x60000020); sigAddress sequence 0,1,2,3 at T+1..T+4.
- Set threshold 33 via cmd 1, then a frame differing by 32 bits -> no irq. cmd 3 clears a previously set flag, and a set in the same DONE cycle keeps motion = 1.
- frameDone at T+3 during READ -> ignored; cmd 4 -> overrunCount 1; frameCount increments only once.
- Reset asserted at T+3 -> IDLE next cycle, all status 0; the next frame is treated as first (no irq).

Source files
------------

// File: rtl/dhash_pkg.sv
//==============================================================================
// Module   : dhash_pkg
// Purpose  : Shared types and constants for the dHash motion controller.
// Revision : 1.0
//==============================================================================
`default_nettype none

package dhash_pkg;

    localparam int SIG_WORD_WIDTH = 32;
    localparam int DIST_WIDTH     = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] CMD_STATUS     = 3'd0;
    localparam logic [2:0] CMD_WR_THRESH  = 3'd1;
    localparam logic [2:0] CMD_RD_THRESH  = 3'd2;
    localparam logic [2:0] CMD_CLR_MOTION = 3'd3;
    localparam logic [2:0] CMD_COUNTERS   = 3'd4;
    localparam logic [2:0] CMD_RD_SIG     = 3'd5;
    localparam logic [2:0] CMD_RST_HIST   = 3'd6;
    localparam logic [2:0] CMD_RSVD       = 3'd7;

    localparam int STAT_BUSY_BIT       = 31;
    localparam int STAT_MOTION_BIT     = 30;
    localparam int STAT_PREV_VALID_BIT = 29;

    function automatic logic [31:0] pack_status(
        input logic                  busy,
        input logic                  motion,
        input logic                  prev_valid,
        input logic [DIST_WIDTH-1:0] distance
    );
        logic [31:0] s;
        s                      = '0;
        s[STAT_BUSY_BIT]       = busy;
        s[STAT_MOTION_BIT]     = motion;
        s[STAT_PREV_VALID_BIT] = prev_valid;
        s[DIST_WIDTH-1:0]      = distance;
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dhash_motion_ctrl_popcount32.sv
//==============================================================================
// Module   : popcount32
// Purpose  : Combinational population count of a 32-bit word (0..32).
// Revision : 1.0
//==============================================================================
`default_nettype none

module popcount32 (
    input  logic [31:0] data,
    output logic [5:0]  count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < 32; i++) begin
            count = count + {5'd0, data[i]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/dhash_motion_ctrl.sv
//==============================================================================
// Module   : dhash_motion_ctrl
// Purpose  : Per-frame signature read-out, Hamming distance vs. previous frame,
//            threshold compare and motion interrupt; CPU access via custom
//            instruction. Optional word mask: DHASH_CTRL_WORDMASK_EN.
// Revision : 1.0
//==============================================================================
`default_nettype none

module dhash_motion_ctrl
    import dhash_pkg::*;
#(
    parameter logic [7:0] customId       = 8'd0,
    parameter int         nrOfWords      = 4,
    parameter logic [7:0] thresholdReset = 8'd10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frameDone,
    output logic [1:0]  sigAddress,
    input  logic [31:0] sigData,
    input  logic [7:0]  ciN,
    input  logic        ciStart,
    input  logic [31:0] ciValueA,
    input  logic [31:0] ciValueB,
    output logic [31:0] ciResult,
    output logic        ciDone,
    output logic        motionIrq
);

    // One extra READ cycle (index == nrOfWords) drains the last RAM read.
    localparam int                IDX_W    = $clog2(nrOfWords + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(nrOfWords);

    state_t                      state;
    state_t                      state_next;
    logic [IDX_W-1:0]            word_idx;
    logic                        addr_phase;
    logic                        capture_en;
    logic [1:0]                  capture_idx;
    logic [DIST_WIDTH-1:0]       acc;
    logic [SIG_WORD_WIDTH-1:0]   prev_word [nrOfWords];
    logic [SIG_WORD_WIDTH-1:0]   diff_word;
    logic [5:0]                  pop_count;
    logic [DIST_WIDTH-1:0]       word_contrib;
    logic                        prev_valid;
    logic                        motion;
    logic [DIST_WIDTH-1:0]       distance;
    logic [DIST_WIDTH-1:0]       threshold;
    logic [15:0]                 frame_count;
    logic [7:0]                  overrun_count;
    logic                        busy;
    logic [2:0]                  cmd;
    logic [31:0]                 status;
    logic [31:0]                 result_sel;
    logic                        word_active;

`ifdef DHASH_CTRL_WORDMASK_EN
    logic [3:0] word_mask;
    logic       unused_ci_bits;
    assign unused_ci_bits = ^{ciValueA[31:3], ciValueB[30:8]};
    assign word_active    = word_mask[capture_idx];
`else
    logic       unused_ci_bits;
    assign unused_ci_bits = ^{ciValueA[31:3], ciValueB[31:8]};
    assign word_active    = 1'b1;
`endif

    assign busy       = (state != ST_IDLE);
    assign addr_phase = (state == ST_READ) && (word_idx < LAST_IDX);
    assign sigAddress = addr_phase ? word_idx[1:0] : 2'd0;
    assign ciDone     = ciStart && (ciN == customId);
    assign cmd        = ciValueA[2:0];
    assign status     = pack_status(busy, motion, prev_valid, distance);

    assign diff_word    = sigData ^ prev_word[capture_idx];
    assign word_contrib = word_active ? {2'd0, pop_count} : '0;

    popcount32 u_popcount (
        .data  (diff_word),
        .count (pop_count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        motionIrq  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (frameDone) begin
                    state_next = ST_READ;
                end
            end
            ST_READ: begin
                if (word_idx == LAST_IDX) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
                motionIrq  = prev_valid && (acc >= threshold);
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            word_idx      <= '0;
            capture_en    <= 1'b0;
            capture_idx   <= '0;
            acc           <= '0;
            prev_valid    <= 1'b0;
            motion        <= 1'b0;
            distance      <= '0;
            threshold     <= thresholdReset;
            frame_count   <= '0;
            overrun_count <= '0;
            for (int i = 0; i < nrOfWords; i++) begin
                prev_word[i] <= '0;
            end
`ifdef DHASH_CTRL_WORDMASK_EN
            word_mask     <= 4'hF;
`endif
        end else begin
            word_idx    <= (state == ST_READ) ? word_idx + 1'b1 : '0;
            capture_en  <= addr_phase;
            capture_idx <= word_idx[1:0];

            if ((state == ST_IDLE) && frameDone) begin
                acc <= '0;
            end else if (capture_en) begin
                acc <= acc + word_contrib;
            end

            if (capture_en) begin
                prev_word[capture_idx] <= sigData;
            end

            if (frameDone && busy && (overrun_count != 8'hFF)) begin
                overrun_count <= overrun_count + 8'd1;
            end

            // A motion set in DONE overrides a simultaneous CPU clear.
            if (motionIrq) begin
                motion <= 1'b1;
            end else if (ciDone && (cmd == CMD_CLR_MOTION)) begin
                motion <= 1'b0;
            end

            if (state == ST_DONE) begin
                distance    <= prev_valid ? acc : '0;
                frame_count <= frame_count + 16'd1;
                prev_valid  <= 1'b1;
            end else if (ciDone && (cmd == CMD_RST_HIST) && !busy) begin
                prev_valid    <= 1'b0;
                frame_count   <= '0;
                overrun_count <= '0;
            end

            if (ciDone && (cmd == CMD_WR_THRESH)) begin
                threshold <= ciValueB[7:0];
            end

`ifdef DHASH_CTRL_WORDMASK_EN
            if (ciDone && (cmd == CMD_RSVD) && !ciValueB[31]) begin
                word_mask <= ciValueB[3:0];
            end
`endif
        end
    end

    always_comb begin
        result_sel = '0;
        case (cmd)
            CMD_STATUS,
            CMD_CLR_MOTION: result_sel = status;
            CMD_RD_THRESH:  result_sel = {24'd0, threshold};
            CMD_COUNTERS:   result_sel = {8'd0, overrun_count, frame_count};
            CMD_RD_SIG:     result_sel = prev_word[ciValueB[1:0]];
            CMD_RST_HIST:   result_sel = {31'd0, busy};
`ifdef DHASH_CTRL_WORDMASK_EN
            CMD_RSVD:       result_sel = ciValueB[31] ? {28'd0, word_mask} : 32'd0;
`endif
            default:        result_sel = '0;
        endcase
        ciResult = ciDone ? result_sel : 32'd0;
    end

endmodule

`default_nettype wire

// File: tb/tb_dhash_motion_ctrl.sv
//==============================================================================
// Module   : tb_dhash_motion_ctrl
// Purpose  : Self-checking bench for dhash_motion_ctrl (default build).
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_dhash_motion_ctrl;
    import dhash_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        frameDone = 1'b0;
    logic [1:0]  sigAddress;
    logic [31:0] sigData;
    logic [7:0]  ciN = 8'd0;
    logic        ciStart = 1'b0;
    logic [31:0] ciValueA = '0;
    logic [31:0] ciValueB = '0;
    logic [31:0] ciResult;
    logic        ciDone;
    logic        motionIrq;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [2:0]  cmd;
        logic [31:0] opb;
        logic [31:0] exp;
        string       name;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    vec_t        vecs [11];
    sb_t         sb [$];
    logic [31:0] ram [4];

    dhash_motion_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .frameDone  (frameDone),
        .sigAddress (sigAddress),
        .sigData    (sigData),
        .ciN        (ciN),
        .ciStart    (ciStart),
        .ciValueA   (ciValueA),
        .ciValueB   (ciValueB),
        .ciResult   (ciResult),
        .ciDone     (ciDone),
        .motionIrq  (motionIrq)
    );

    always #5 clock = ~clock;

    // Synchronous signature RAM: data valid one cycle after the address.
    always @(posedge clock) sigData <= ram[sigAddress];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic ci_drive(input logic [2:0] cmd, input logic [31:0] opb,
                            input logic [31:0] exp, input string name);
        ciStart  = 1'b1;
        ciN      = 8'd0;
        ciValueA = {29'd0, cmd};
        ciValueB = opb;
        sb.push_back('{name, exp});
    endtask

    task automatic ci_release();
        ciStart  = 1'b0;
        ciValueA = '0;
        ciValueB = '0;
    endtask

    task automatic sample_ci();
        sb_t e;
        if (ciDone) begin
            if (sb.size() == 0) begin
                check("ci_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check(e.name, ciResult, e.exp);
            end
        end
    endtask

    // Phase convention: every task starts and ends 1 time unit after a rising edge.
    task automatic ci_cmd(input logic [2:0] cmd, input logic [31:0] opb,
                          input logic [31:0] exp, input string name);
        ci_drive(cmd, opb, exp, name);
        @(negedge clock);
        sample_ci();
        @(posedge clock); #1;
        ci_release();
    endtask

    task automatic run_frame(input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3,
                             input bit exp_irq, input int inject_k, input bit inject_reset,
                             input int ci_k, input logic [2:0] ci_c, input logic [31:0] ci_b,
                             input logic [31:0] ci_e, input string name);
        logic [7:0] irq_vec;
        logic [7:0] addr_vec;
        ram[0] = w0; ram[1] = w1; ram[2] = w2; ram[3] = w3;
        irq_vec  = '0;
        addr_vec = '0;
        frameDone = 1'b1;
        @(negedge clock);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clock); #1;
            frameDone = 1'b0;
            reset     = 1'b0;
            ci_release();
            if (k == inject_k) begin
                if (inject_reset) reset = 1'b1;
                else              frameDone = 1'b1;
            end
            if (k == ci_k) ci_drive(ci_c, ci_b, ci_e, {name, "_ci"});
            @(negedge clock);
            irq_vec[k-1] = motionIrq;
            if (k <= 4) addr_vec[2*(k-1) +: 2] = sigAddress;
            if (inject_reset && (k == inject_k + 1))
                check({name, "_reset_idle_addr"}, {30'd0, sigAddress}, 32'd0);
            sample_ci();
        end
        @(posedge clock); #1;
        ci_release();
        reset = 1'b0;
        check({name, "_irq_timing"}, {24'd0, irq_vec}, exp_irq ? 32'h20 : 32'h0);
        if (!inject_reset)
            check({name, "_addr_seq"}, {24'd0, addr_vec}, 32'hE4);
    endtask

    initial begin
        vecs[0]  = '{CMD_RD_THRESH,  32'h0,        32'd10,  "rd_thresh_rst"};
        vecs[1]  = '{CMD_STATUS,     32'h0,        32'h0,   "status_rst"};
        vecs[2]  = '{CMD_COUNTERS,   32'h0,        32'h0,   "counters_rst"};
        vecs[3]  = '{CMD_RD_SIG,     32'h0,        32'h0,   "sig0_rst"};
        vecs[4]  = '{CMD_RD_SIG,     32'h3,        32'h0,   "sig3_rst"};
        vecs[5]  = '{CMD_RSVD,       32'h0,        32'h0,   "rsvd"};
        vecs[6]  = '{CMD_RST_HIST,   32'h0,        32'h0,   "hist_rst_idle"};
        vecs[7]  = '{CMD_WR_THRESH,  32'h55,       32'h0,   "wr_thresh_55"};
        vecs[8]  = '{CMD_RD_THRESH,  32'h0,        32'h55,  "rd_thresh_55"};
        vecs[9]  = '{CMD_WR_THRESH,  32'hFFFFFF0A, 32'h0,   "wr_thresh_10"};
        vecs[10] = '{CMD_RD_THRESH,  32'h0,        32'd10,  "rd_thresh_10"};
        for (int i = 0; i < 4; i++) ram[i] = '0;

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_sig_address", {30'd0, sigAddress}, 32'd0);
        check("rst_motion_irq",  {31'd0, motionIrq},  32'd0);
        check("idle_ci_done",    {31'd0, ciDone},     32'd0);
        @(posedge clock); #1;

        ciStart = 1'b1; ciN = 8'h05; ciValueA = 32'h0;
        @(negedge clock);
        check("other_id_done",   {31'd0, ciDone}, 32'd0);
        check("other_id_result", ciResult,        32'd0);
        @(posedge clock); #1;
        ci_release();
        ciN = 8'd0;

        for (int i = 0; i < 11; i++) ci_cmd(vecs[i].cmd, vecs[i].opb, vecs[i].exp, vecs[i].name);

        // First frame only establishes history.
        run_frame(32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "f1");
        ci_cmd(CMD_STATUS,   0, 32'h20000000, "f1_status");
        ci_cmd(CMD_RD_SIG,   0, 32'hFFFFFFFF, "f1_sig0");
        ci_cmd(CMD_COUNTERS, 0, 32'h00000001, "f1_counters");

        run_frame(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, "f2");
        ci_cmd(CMD_STATUS,   0, 32'h60000020, "f2_status");
        ci_cmd(CMD_COUNTERS, 0, 32'h00000002, "f2_counters");

        ci_cmd(CMD_WR_THRESH, 33, 0, "wr_thresh_33");
        run_frame(0, 32'h0000FFFF, 32'hFFFF0000, 0, 0, 0, 0, 0, 0, 0, 0, "f3");
        ci_cmd(CMD_STATUS,     0, 32'h60000020, "f3_status");
        ci_cmd(CMD_CLR_MOTION, 0, 32'h60000020, "f3_clear");
        ci_cmd(CMD_STATUS,     0, 32'h20000020, "f3_status_cleared");

        // Distance 96 would exceed 33; the threshold raised during READ must apply.
        run_frame(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0,
                  2, CMD_WR_THRESH, 32'd100, 32'h0, "f4");
        ci_cmd(CMD_STATUS, 0, 32'h20000060, "f4_status");

        // Clear in the same DONE cycle as a new detection: detection wins.
        run_frame(0, 0, 0, 0, 1, 0, 0, 6, CMD_CLR_MOTION, 0, 32'hA0000060, "f5");
        ci_cmd(CMD_STATUS, 0, 32'h60000080, "f5_status");

        run_frame(0, 0, 0, 0, 0, 3, 0, 3, CMD_RST_HIST, 0, 32'h1, "f6");
        ci_cmd(CMD_COUNTERS, 0, 32'h00010006, "f6_counters");
        ci_cmd(CMD_STATUS,   0, 32'h60000000, "f6_status");

        run_frame(32'h12345678, 1, 2, 3, 0, 3, 1, 0, 0, 0, 0, "f7");
        ci_cmd(CMD_STATUS,    0, 32'h0,    "f7_status");
        ci_cmd(CMD_COUNTERS,  0, 32'h0,    "f7_counters");
        ci_cmd(CMD_RD_SIG,    0, 32'h0,    "f7_sig0");
        ci_cmd(CMD_RD_THRESH, 0, 32'd10,   "f7_thresh");

        run_frame(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0, "f8");
        ci_cmd(CMD_STATUS,   0, 32'h20000000, "f8_status");
        ci_cmd(CMD_RD_SIG,   2, 32'hFFFFFFFF, "f8_sig2");
        ci_cmd(CMD_COUNTERS, 0, 32'h00000001, "f8_counters");

        run_frame(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, "f9");
        ci_cmd(CMD_STATUS,   0, 32'h60000080, "f9_status");
        ci_cmd(CMD_RST_HIST, 0, 32'h0,        "f9_hist_rst");
        ci_cmd(CMD_STATUS,   0, 32'h40000080, "f9_status_hist");
        ci_cmd(CMD_COUNTERS, 0, 32'h0,        "f9_counters");

        check("sb_drain", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
